// File: rtl/pipelined_adder_pkg.sv
// Shared types and elaboration helpers for the pipelined ripple-carry adder.
// The optional signed-overflow output is enabled by defining PIPELINED_ADDER_OVF_EN.
package pipelined_adder_pkg;

    // Control half of the per-stage payload; the data half (sum, skewed A/B) is WIDTH-dependent.
    typedef struct packed {
        logic valid;
        logic carry;
    } stage_flags_t;

    function automatic int unsigned slice_w(input int unsigned width, input int unsigned stages);
        return (stages == 0) ? 0 : width / stages;
    endfunction

    function automatic bit cfg_ok(input int unsigned width, input int unsigned stages);
        return (width >= 1) && (stages >= 1) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/adder_slice.sv
// One SLICE-bit ripple-add pipeline stage: adds its slice of the skewed operands
// plus the upstream carry, and registers the whole payload when load is high.
module adder_slice
    import pipelined_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 8,
    parameter int unsigned LO    = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             up_valid,
    input  logic             up_carry,
    input  logic [WIDTH-1:0] up_sum,
    input  logic [WIDTH-1:0] up_a,
    input  logic [WIDTH-1:0] up_b,
    output logic             valid,
    output logic             carry,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b
);

    logic [SLICE:0]   part;
    logic [WIDTH-1:0] sum_next;
    stage_flags_t     flags_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    always_comb begin
        part = (SLICE+1)'(up_a[LO +: SLICE]) + (SLICE+1)'(up_b[LO +: SLICE])
             + (SLICE+1)'(up_carry);
        sum_next = up_sum;
        sum_next[LO +: SLICE] = part[SLICE-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
            sum_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else if (load) begin
            flags_q.valid <= up_valid;
            flags_q.carry <= part[SLICE];
            sum_q         <= sum_next;
            a_q           <= up_a;
            b_q           <= up_b;
        end
    end

    assign valid = flags_q.valid;
    assign carry = flags_q.carry;
    assign sum   = sum_q;
    assign a     = a_q;
    assign b     = b_q;

endmodule

// File: rtl/pipelined_adder.sv
// Streaming A+B+Cin adder with the carry chain split over STAGES registered slices and
// bubble-collapsing valid/ready flow control. Define PIPELINED_ADDER_OVF_EN for the Ovf output.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             out_valid,
    input  logic             out_ready
`ifdef PIPELINED_ADDER_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int unsigned SLICE = slice_w(WIDTH, STAGES);

    if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
        $error("pipelined_adder: WIDTH must be a nonzero multiple of STAGES");
    end

    // Index 0 is the input port; index k+1 is the output of stage k.
    logic [STAGES:0]  valid_c;
    logic [STAGES:0]  carry_c;
    logic [WIDTH-1:0] sum_c [STAGES+1];
    logic [WIDTH-1:0] a_c   [STAGES+1];
    logic [WIDTH-1:0] b_c   [STAGES+1];
    logic [STAGES-1:0] advance;
    logic [STAGES-1:0] load;

    assign valid_c[0] = in_valid;
    assign carry_c[0] = Cin;
    assign sum_c[0]   = '0;
    assign a_c[0]     = A;
    assign b_c[0]     = B;

    // A stage advances when out_ready is high or any stage downstream of it holds a bubble,
    // which is the unrolled form of the recursive advance chain.
    always_comb begin
        logic go;
        go      = out_ready;
        advance = '0;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            advance[k] = valid_c[k+1] && go;
            go         = go || !valid_c[k+1];
        end
        load = ~valid_c[STAGES:1] | advance;
    end

    assign in_ready = load[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_slice #(
            .WIDTH (WIDTH),
            .SLICE (SLICE),
            .LO    (k * SLICE)
        ) u_slice (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (load[k]),
            .up_valid (valid_c[k]),
            .up_carry (carry_c[k]),
            .up_sum   (sum_c[k]),
            .up_a     (a_c[k]),
            .up_b     (b_c[k]),
            .valid    (valid_c[k+1]),
            .carry    (carry_c[k+1]),
            .sum      (sum_c[k+1]),
            .a        (a_c[k+1]),
            .b        (b_c[k+1])
        );
    end

    assign Sum       = sum_c[STAGES];
    assign Cout      = carry_c[STAGES];
    assign out_valid = valid_c[STAGES];

`ifdef PIPELINED_ADDER_OVF_EN
    logic [SLICE-1:0] msb_part;
    logic             cmsb_d;
    logic             cmsb_q;

    // Carry into the MSB recovered from the last slice's add: c = a ^ b ^ s at bit WIDTH-1.
    always_comb begin
        msb_part = a_c[STAGES-1][WIDTH-1 -: SLICE] + b_c[STAGES-1][WIDTH-1 -: SLICE]
                 + SLICE'(carry_c[STAGES-1]);
        cmsb_d   = a_c[STAGES-1][WIDTH-1] ^ b_c[STAGES-1][WIDTH-1] ^ msb_part[SLICE-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmsb_q <= 1'b0;
        end else if (load[STAGES-1]) begin
            cmsb_q <= cmsb_d;
        end
    end

    assign Ovf = cmsb_q ^ Cout;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed self-checking bench for pipelined_adder (32/4 instance plus a 1/1 full-adder instance).
module tb_pipelined_adder;

    logic        clk;
    logic        rst_n;
    logic [31:0] a, b, sum;
    logic        cin, in_valid, in_ready, cout, out_valid, out_ready, ovf;
    logic        a1, b1, cin1, iv1, ir1, s1, co1, ov1, or1, ovf1;

    int total = 0;
    int bad   = 0;

    pipelined_adder #(.WIDTH(32), .STAGES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (a),
        .B         (b),
        .Cin       (cin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Sum       (sum),
        .Cout      (cout),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef PIPELINED_ADDER_OVF_EN
        ,
        .Ovf       (ovf)
`endif
    );

    pipelined_adder #(.WIDTH(1), .STAGES(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (a1),
        .B         (b1),
        .Cin       (cin1),
        .in_valid  (iv1),
        .in_ready  (ir1),
        .Sum       (s1),
        .Cout      (co1),
        .out_valid (ov1),
        .out_ready (or1)
`ifdef PIPELINED_ADDER_OVF_EN
        ,
        .Ovf       (ovf1)
`endif
    );

`ifndef PIPELINED_ADDER_OVF_EN
    assign ovf  = 1'b0;
    assign ovf1 = 1'b0;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

`ifdef PIPELINED_ADDER_OVF_EN
    task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic tc);
        @(negedge clk);
        a = ta; b = tb; cin = tc; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_out(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            if (out_valid) ok = 1'b1;
        end
    endtask
`endif

    // {Cout,Sum} for index {A,B,Cin}
    logic [1:0]  fa_exp [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    logic [31:0] sa [8] = '{32'h00000001, 32'hFFFFFFFF, 32'h12345678, 32'h80000000,
                            32'hAAAAAAAA, 32'hF0F0F0F0, 32'h00010000, 32'hFFFFFFFF};
    logic [31:0] sb [8] = '{32'h00000002, 32'h00000001, 32'h87654321, 32'h80000000,
                            32'h55555555, 32'h0F0F0F0F, 32'h0000FFFF, 32'hFFFFFFFF};
    logic        sc [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [32:0] se [8] = '{33'h000000003, 33'h100000000, 33'h09999999A, 33'h100000000,
                            33'h0FFFFFFFF, 33'h100000000, 33'h000020000, 33'h1FFFFFFFF};

    logic [31:0] bp_a [6] = '{32'h100, 32'h200, 32'h300, 32'h400, 32'h500, 32'h600};
    logic [31:0] bp_e [4] = '{32'h101, 32'h201, 32'h301, 32'h401};

    initial begin
        int  idx;
        int  got;
        bit  fire;
        bit  ok;

        rst_n = 1'b0;
        a = '0; b = '0; cin = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0; iv1 = 1'b0; or1 = 1'b1;

        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full-adder truth table on the 1-bit, 1-stage instance.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a1 = i[2]; b1 = i[1]; cin1 = i[0]; iv1 = 1'b1;
            @(posedge clk);
            #1;
            check("fa_valid", ov1, 1);
            check("fa_sum", s1, fa_exp[i][0]);
            check("fa_cout", co1, fa_exp[i][1]);
        end
        @(negedge clk);
        iv1 = 1'b0;

        // Carry ripples through all four slices; result appears after the fourth edge.
        a = 32'hFFFFFFFF; b = 32'h0; cin = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) begin
            check("lat_early", out_valid, 0);
            @(negedge clk);
        end
        check("lat_valid", out_valid, 1);
        check("lat_sum", sum, 32'h0);
        check("lat_cout", cout, 1);
        @(negedge clk);
        check("lat_drained", out_valid, 0);

        // Back-to-back stream with out_ready held high.
        for (int n = 0; n < 13; n++) begin
            if (n >= 4 && n < 12) begin
                check("stream_valid", out_valid, 1);
                check("stream_sum", {cout, sum}, se[n-4]);
            end else begin
                check("stream_idle", out_valid, 0);
            end
            if (n < 8) begin
                a = sa[n]; b = sb[n]; cin = sc[n]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (n < 8) check("stream_ready", in_ready, 1);
            @(negedge clk);
        end

        // Backpressure: six offered cycles with out_ready low fill exactly four stages.
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            a = bp_a[idx]; b = 32'h1; cin = 1'b0; in_valid = 1'b1;
            #1 fire = in_ready;
            @(negedge clk);
            if (fire) idx++;
        end
        in_valid = 1'b0;
        check("bp_accepted", idx, 4);
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        check("bp_sum", sum, 32'h101);
        repeat (2) @(negedge clk);
        check("bp_hold_sum", sum, 32'h101);
        check("bp_hold_ready", in_ready, 0);

        // Full pipeline with an output transfer frees stage 0 in the same cycle.
        out_ready = 1'b1;
        #1 check("full_pass_ready", in_ready, 1);
        got = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) begin
                if (got < 4) check("drain_sum", sum, bp_e[got]);
                else check("drain_extra", got, 3);
                got++;
            end
            @(negedge clk);
        end
        check("drain_count", got, 4);

        // Asynchronous reset with three transactions in flight.
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            a = 32'h1111 * (c + 1); b = 32'h2222; cin = 1'b0; in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_sum", sum, 32'h3333);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_sum", sum, 0);
        check("mid_rst_cout", cout, 0);
        check("mid_rst_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("post_rst_quiet", out_valid, 0);
            @(negedge clk);
        end
        check("post_rst_ready", in_ready, 1);

`ifdef PIPELINED_ADDER_OVF_EN
        send(32'h7FFFFFFF, 32'h00000001, 1'b0);
        wait_out(ok);
        if (!ok) check("ovf1_timeout", 0, 1);
        check("ovf1_sum", sum, 32'h80000000);
        check("ovf1_ovf", ovf, 1);
        check("ovf1_cout", cout, 0);

        send(32'h80000000, 32'h80000000, 1'b0);
        wait_out(ok);
        if (!ok) check("ovf2_timeout", 0, 1);
        check("ovf2_sum", sum, 32'h0);
        check("ovf2_ovf", ovf, 1);
        check("ovf2_cout", cout, 1);

        send(32'h5, 32'h3, 1'b0);
        wait_out(ok);
        if (!ok) check("ovf3_timeout", 0, 1);
        check("ovf3_sum", sum, 32'h8);
        check("ovf3_ovf", ovf, 0);
        @(negedge clk);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
